// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, fetch FSM states and instruction field positions.
// FETCH_RESET_VECTOR_EN adds the VEC_LO/VEC_HI reset-vector states.
package pipeline_pkg;

    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 7;
    localparam int unsigned RSRC_MSB = 6;
    localparam int unsigned RSRC_LSB = 4;
    localparam int unsigned RDST_MSB = 3;
    localparam int unsigned RDST_LSB = 1;

    localparam logic [8:0] OPC_NOP = 9'b000_00000;
    localparam logic [8:0] OPC_LDM = 9'b011_00010;
    localparam logic [8:0] OPC_LDD = 9'b011_00011;
    localparam logic [8:0] OPC_STD = 9'b011_00100;

`ifdef FETCH_RESET_VECTOR_EN
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        IMM    = 2'd1,
        VEC_LO = 2'd2,
        VEC_HI = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        IMM   = 2'd1
    } fetch_state_t;
`endif

    typedef struct packed {
        logic [8:0] opcode;
        logic [2:0] rsrc;
        logic [2:0] rdst;
    } instr_fields_t;

    function automatic logic is_two_word(input logic [8:0] opc);
        return opc inside {OPC_LDM, OPC_LDD, OPC_STD};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with +1 incrementer and load mux; load wins over increment.
module pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1
);

    assign pc_plus1 = pc + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_VAL;
        end else if (load) begin
            pc <= load_value;
        end else if (en) begin
            pc <= pc_plus1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one/two-word fetch FSM feeding the IF/ID register.
// FETCH_RESET_VECTOR_EN: reset fetches the start PC from memory words 0 and 1.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        ifid_valid,
    output logic [8:0]  ifid_opcode,
    output logic [2:0]  ifid_rsrc,
    output logic [2:0]  ifid_rdst,
    output logic [15:0] ifid_imm,
    output logic [31:0] ifid_pc_next
);

`ifdef FETCH_RESET_VECTOR_EN
    localparam logic [31:0] PC_AT_RESET = 32'h0000_0000;
    localparam fetch_state_t STATE_AT_RESET = VEC_LO;
    logic [15:0] vec_lo;
    logic        vec_latch;
`else
    localparam logic [31:0] PC_AT_RESET = RESET_PC;
    localparam fetch_state_t STATE_AT_RESET = FETCH;
`endif

    fetch_state_t  state, state_next;
    instr_fields_t cur, held;
    logic          two_word;
    logic          pc_en, pc_load;
    logic [31:0]   pc, pc_plus1, pc_load_value;
    logic          ifid_bubble, ifid_one, ifid_two;
    logic          latch_word, clear_word;

    pc_reg #(
        .RESET_VAL(PC_AT_RESET)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (pc_en),
        .load      (pc_load),
        .load_value(pc_load_value),
        .pc        (pc),
        .pc_plus1  (pc_plus1)
    );

    assign imem_addr = pc;

    always_comb begin
        cur.opcode = imem_data[OPC_MSB:OPC_LSB];
        cur.rsrc   = imem_data[RSRC_MSB:RSRC_LSB];
        cur.rdst   = imem_data[RDST_MSB:RDST_LSB];
    end

    assign two_word = is_two_word(cur.opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STATE_AT_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (branch_taken) begin
            state_next = FETCH;
        end else begin
            case (state)
                FETCH:   if (!stall && two_word) state_next = IMM;
                IMM:     if (!stall) state_next = FETCH;
`ifdef FETCH_RESET_VECTOR_EN
                VEC_LO:  state_next = VEC_HI;
                VEC_HI:  state_next = FETCH;
`endif
                default: state_next = FETCH;
            endcase
        end
    end

    // Branch overrides everything; stall/flush only matter in FETCH and IMM.
    always_comb begin
        pc_en         = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = branch_target;
        ifid_bubble   = 1'b0;
        ifid_one      = 1'b0;
        ifid_two      = 1'b0;
        latch_word    = 1'b0;
        clear_word    = 1'b0;
`ifdef FETCH_RESET_VECTOR_EN
        vec_latch     = 1'b0;
`endif
        if (branch_taken) begin
            pc_load     = 1'b1;
            ifid_bubble = 1'b1;
            clear_word  = 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        pc_en = 1'b1;
                        if (two_word) begin
                            latch_word  = 1'b1;
                            ifid_bubble = 1'b1;
                        end else if (flush) begin
                            ifid_bubble = 1'b1;
                        end else begin
                            ifid_one = 1'b1;
                        end
                    end else if (flush) begin
                        ifid_bubble = 1'b1;
                    end
                end
                IMM: begin
                    if (!stall) begin
                        pc_en = 1'b1;
                        if (flush) ifid_bubble = 1'b1;
                        else       ifid_two    = 1'b1;
                    end else if (flush) begin
                        ifid_bubble = 1'b1;
                    end
                end
`ifdef FETCH_RESET_VECTOR_EN
                VEC_LO: begin
                    pc_load       = 1'b1;
                    pc_load_value = 32'd1;
                    vec_latch     = 1'b1;
                end
                VEC_HI: begin
                    pc_load       = 1'b1;
                    pc_load_value = {imem_data, vec_lo};
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= '0;
        end else if (clear_word) begin
            held <= '0;
        end else if (latch_word) begin
            held <= cur;
        end
    end

`ifdef FETCH_RESET_VECTOR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_lo <= '0;
        end else if (vec_latch) begin
            vec_lo <= imem_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid   <= 1'b0;
            ifid_opcode  <= OPC_NOP;
            ifid_rsrc    <= '0;
            ifid_rdst    <= '0;
            ifid_imm     <= '0;
            ifid_pc_next <= '0;
        end else if (ifid_bubble) begin
            ifid_valid   <= 1'b0;
            ifid_opcode  <= OPC_NOP;
            ifid_rsrc    <= '0;
            ifid_rdst    <= '0;
            ifid_imm     <= '0;
            ifid_pc_next <= '0;
        end else if (ifid_one) begin
            ifid_valid   <= 1'b1;
            ifid_opcode  <= cur.opcode;
            ifid_rsrc    <= cur.rsrc;
            ifid_rdst    <= cur.rdst;
            ifid_imm     <= '0;
            ifid_pc_next <= pc_plus1;
        end else if (ifid_two) begin
            ifid_valid   <= 1'b1;
            ifid_opcode  <= held.opcode;
            ifid_rsrc    <= held.rsrc;
            ifid_rdst    <= held.rdst;
            ifid_imm     <= imem_data;
            ifid_pc_next <= pc_plus1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed program, expected IF/ID words queued by stimulus.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        ifid_valid;
    logic [8:0]  ifid_opcode;
    logic [2:0]  ifid_rsrc;
    logic [2:0]  ifid_rdst;
    logic [15:0] ifid_imm;
    logic [31:0] ifid_pc_next;

    logic [15:0] mem [256];
    assign imem_data = mem[imem_addr[7:0]];

    typedef struct packed {
        logic [8:0]  opc;
        logic [2:0]  rsrc;
        logic [2:0]  rdst;
        logic [15:0] imm;
        logic [31:0] pc_next;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .ifid_valid   (ifid_valid),
        .ifid_opcode  (ifid_opcode),
        .ifid_rsrc    (ifid_rsrc),
        .ifid_rdst    (ifid_rdst),
        .ifid_imm     (ifid_imm),
        .ifid_pc_next (ifid_pc_next)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic push(input logic [8:0] opc, input logic [2:0] rsrc, input logic [2:0] rdst,
                        input logic [15:0] imm, input logic [31:0] pc_next);
        exp_t e;
        e.opc = opc; e.rsrc = rsrc; e.rdst = rdst; e.imm = imm; e.pc_next = pc_next;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string name);
        check({name, "_valid"},  32'(ifid_valid), 32'd0);
        check({name, "_opcode"}, 32'(ifid_opcode), 32'd0);
        check({name, "_imm"},    32'(ifid_imm), 32'd0);
    endtask

    // Monitor: checks each freshly loaded IF/ID instruction (stall cycles only hold the old one).
    initial begin
        logic stall_at_edge;
        exp_t e;
        forever begin
            @(posedge clk);
            stall_at_edge = stall;
            @(negedge clk);
            if (rst_n && ifid_valid && !stall_at_edge) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: opcode %h pc_next %h, none required",
                             ifid_opcode, ifid_pc_next);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_opcode",  32'(ifid_opcode), 32'(e.opc));
                    check("sb_rsrc",    32'(ifid_rsrc), 32'(e.rsrc));
                    check("sb_rdst",    32'(ifid_rdst), 32'(e.rdst));
                    check("sb_imm",     32'(ifid_imm), 32'(e.imm));
                    check("sb_pc_next", ifid_pc_next, e.pc_next);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0080;  // SETC, op 001
        mem[8'h01] = 16'h1A3C;  // op 034 rsrc 3 rdst 6
        mem[8'h02] = 16'h0000;  // NOP
        mem[8'h03] = 16'hFFFE;  // op 1FF rsrc 7 rdst 7
        mem[8'h04] = 16'h3100;  // LDM
        mem[8'h05] = 16'hBEEF;
        mem[8'h06] = 16'h31AA;  // LDD rsrc 2 rdst 5
        mem[8'h07] = 16'h1234;
        mem[8'h08] = 16'h3200;  // STD
        mem[8'h09] = 16'h7777;
        mem[8'h40] = 16'h0080;
        mem[8'h41] = 16'h1A3C;
        mem[8'h42] = 16'h3100;
        mem[8'h43] = 16'h5555;
        mem[8'h44] = 16'h1A3C;
        mem[8'hFF] = 16'h0080;
`ifdef FETCH_RESET_VECTOR_EN
        mem[8'h00] = 16'h0010;
        mem[8'h01] = 16'h0002;

        #1 rst_n = 1'b0;
        #1;
        check("vec_reset_addr", imem_addr, 32'h0);
        check("vec_reset_valid", 32'(ifid_valid), 32'd0);
        stall = 1'b1;
        flush = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("vec_lo_addr", imem_addr, 32'h1);
        check("vec_lo_valid", 32'(ifid_valid), 32'd0);
        cyc();
        check("vec_hi_addr", imem_addr, 32'h0002_0010);
        check("vec_hi_valid", 32'(ifid_valid), 32'd0);
        stall = 1'b0;
        flush = 1'b0;
        push(9'h000, 3'd0, 3'd0, 16'h0, 32'h0002_0011);
        cyc();
        check("vec_first_fetch_addr", imem_addr, 32'h0002_0011);
`else
        // Asynchronous reset with no clock edge pending
        #1 rst_n = 1'b0;
        #1;
        check("reset_valid", 32'(ifid_valid), 32'd0);
        check("reset_opcode", 32'(ifid_opcode), 32'd0);
        check("reset_pc_next", ifid_pc_next, 32'd0);
        check("reset_addr", imem_addr, 32'h0);
        cyc();
        check("reset_hold_addr", imem_addr, 32'h0);
        rst_n = 1'b1;

        push(9'h001, 3'd0, 3'd0, 16'h0, 32'd1);
        cyc();
        check("setc_addr", imem_addr, 32'd1);
        push(9'h034, 3'd3, 3'd6, 16'h0, 32'd2);
        cyc();
        push(9'h000, 3'd0, 3'd0, 16'h0, 32'd3);
        cyc();
        push(9'h1FF, 3'd7, 3'd7, 16'h0, 32'd4);
        cyc();
        check("pre_ldm_addr", imem_addr, 32'd4);
        cyc();
        check_bubble("ldm_bubble");
        check("ldm_imm_addr", imem_addr, 32'd5);
        push(9'h062, 3'd0, 3'd0, 16'hBEEF, 32'd6);
        cyc();
        check("ldm_done_addr", imem_addr, 32'd6);

        stall = 1'b1;
        repeat (3) cyc();
        check("stall_addr", imem_addr, 32'd6);
        check("stall_valid", 32'(ifid_valid), 32'd1);
        check("stall_opcode", 32'(ifid_opcode), 32'h062);
        check("stall_imm", 32'(ifid_imm), 32'hBEEF);
        check("stall_pc_next", ifid_pc_next, 32'd6);
        flush = 1'b1;
        cyc();
        check_bubble("stall_flush");
        check("stall_flush_addr", imem_addr, 32'd6);
        stall = 1'b0;
        flush = 1'b0;

        cyc();
        push(9'h063, 3'd2, 3'd5, 16'h1234, 32'd8);
        cyc();
        check("ldd_done_addr", imem_addr, 32'd8);

        // Branch taken while in IMM, with stall also high
        cyc();
        branch_taken = 1'b1;
        branch_target = 32'h40;
        stall = 1'b1;
        cyc();
        branch_taken = 1'b0;
        stall = 1'b0;
        check("branch_addr", imem_addr, 32'h40);
        check("branch_valid", 32'(ifid_valid), 32'd0);
        push(9'h001, 3'd0, 3'd0, 16'h0, 32'h41);
        cyc();

        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check_bubble("flush_fetch");
        check("flush_fetch_addr", imem_addr, 32'h42);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check_bubble("flush_imm");
        check("flush_imm_addr", imem_addr, 32'h44);
        push(9'h034, 3'd3, 3'd6, 16'h0, 32'h45);
        cyc();

        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        cyc();
        branch_taken = 1'b0;
        check("max_pc_addr", imem_addr, 32'hFFFF_FFFF);
        push(9'h001, 3'd0, 3'd0, 16'h0, 32'h0);
        cyc();
        check("pc_wrap_addr", imem_addr, 32'h0);

        // Asynchronous reset while IF/ID holds a valid instruction
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ifid_valid), 32'd0);
        check("async_rst_opcode", 32'(ifid_opcode), 32'd0);
        rst_n = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'd4;
        cyc();
        branch_taken = 1'b0;
        cyc();
        check("in_imm_addr", imem_addr, 32'd5);

        // Asynchronous reset mid-IMM discards the partial LDM
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_imm_rst_addr", imem_addr, 32'h0);
        check("mid_imm_rst_valid", 32'(ifid_valid), 32'd0);
        check("mid_imm_rst_pc_next", ifid_pc_next, 32'd0);
        rst_n = 1'b1;
        push(9'h001, 3'd0, 3'd0, 16'h0, 32'd1);
        cyc();
        check("post_rst_addr", imem_addr, 32'd1);
`endif
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
